// File: rtl/alu_host_driver.sv
// -----------------------------------------------------------------------------
// alu_host_driver
//   Bridges a valid/ready host request/response channel onto the byte-wide
//   shared bus of an ALU wrapper. Each request is sent as a fixed sequence
//   (A, B, command). The driver then waits for the wrapper's Done flag, captures
//   the low and high result bytes and presents them as one response. If Done
//   never arrives within TIMEOUT wait cycles, the response is flagged as an error.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready host request handshake
//   req_a, req_b        operand bytes
//   req_cmd             command byte {MUL, BCD, shr, CI, op[3:0]}
//   rsp_valid/rsp_ready host response handshake
//   rsp_lo, rsp_hi      result bytes (ALU result + flags, or 16-bit product)
//   rsp_err             Done did not arrive within TIMEOUT
//   ABCmd_o             shared operand/command bus to the ALU wrapper
//   LoadA_o/LoadB_o/LoadCmd_o  load strobes to the ALU wrapper
//   ACC_i, Done_i       wrapper result byte and done flag
// -----------------------------------------------------------------------------
module alu_host_driver #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_cmd,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_lo,
  output logic [7:0] rsp_hi,
  output logic       rsp_err,
  output logic [7:0] ABCmd_o,
  output logic       LoadA_o,
  output logic       LoadB_o,
  output logic       LoadCmd_o,
  input  logic [7:0] ACC_i,
  input  logic       Done_i
);

  // Counter must hold the value TIMEOUT itself; it never counts past it.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SEND_A, HOLD_A, HOLD_B, EXEC, WAIT_DONE, CAP_HI, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d, cmd_q, cmd_d;
  logic [7:0]    lo_q, lo_d, hi_q, hi_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;

  // Outputs are registered, decoded from the state being entered.
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d, load_cmd_q, load_cmd_d;
  logic [7:0]    bus_q, bus_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    wait_d  = wait_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          cmd_d   = req_cmd;
          err_d   = 1'b0;
          wait_d  = '0;
          state_d = SEND_A;
        end
      end
      SEND_A: state_d = HOLD_A;
      HOLD_A: state_d = HOLD_B;
      HOLD_B: state_d = EXEC;
      EXEC:   state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (Done_i) begin
          lo_d    = ACC_i;
          state_d = CAP_HI;
        end else begin
          wait_d = wait_q + CW'(1);
          if (wait_d == CW'(TIMEOUT)) begin
            err_d   = 1'b1;
            lo_d    = 8'h00;
            hi_d    = 8'h00;
            state_d = RESP;
          end
        end
      end
      CAP_HI: begin
        hi_d    = ACC_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Output decode for the next state. HOLD_A still drives A: the wrapper
    // captures the bus one cycle after each strobe.
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    load_cmd_d  = 1'b0;
    bus_d       = 8'h00;
    case (state_d)
      IDLE:   req_ready_d = 1'b1;
      SEND_A: begin bus_d = a_d; load_a_d   = 1'b1; end
      HOLD_A: begin bus_d = a_d; load_b_d   = 1'b1; end
      HOLD_B: begin bus_d = b_d; load_cmd_d = 1'b1; end
      // CAP_HI keeps the command on the bus so MUL stays visible while the
      // wrapper produces the high byte.
      EXEC, WAIT_DONE, CAP_HI: bus_d = cmd_d;
      RESP:   rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cmd_q       <= 8'h00;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      err_q       <= 1'b0;
      wait_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      load_cmd_q  <= 1'b0;
      bus_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cmd_q       <= cmd_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      load_cmd_q  <= load_cmd_d;
      bus_q       <= bus_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_err   = err_q;
  assign ABCmd_o   = bus_q;
  assign LoadA_o   = load_a_q;
  assign LoadB_o   = load_b_q;
  assign LoadCmd_o = load_cmd_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_host_driver
//   Random and directed stimulus for alu_host_driver. A cycle-accurate ALU
//   wrapper model sits on the shared bus. Expected responses are queued when a
//   request is accepted, and a separate monitor pops and compares them on
//   every response handshake.
// -----------------------------------------------------------------------------
module tb_alu_host_driver;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = 8'h00, req_b = 8'h00, req_cmd = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_lo, rsp_hi;
  logic       rsp_err;
  logic [7:0] ABCmd_o;
  logic       LoadA_o, LoadB_o, LoadCmd_o;
  logic [7:0] ACC_i;
  logic       Done_i;

  always #5 clk = ~clk;

  alu_host_driver #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
    .ABCmd_o(ABCmd_o), .LoadA_o(LoadA_o), .LoadB_o(LoadB_o), .LoadCmd_o(LoadCmd_o),
    .ACC_i(ACC_i), .Done_i(Done_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {flags, result} for non-MUL commands, product for MUL.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [8:0] s;
    logic [4:0] h;
    logic [7:0] r;
    logic       co, v, hc;
    if (c[7]) return 16'(a) * 16'(b);
    co = 1'b0; v = 1'b0; hc = 1'b0; s = 9'd0; h = 5'd0;
    case (c[3:0])
      4'd0: begin
        s  = {1'b0, a} + {1'b0, b} + {8'd0, c[4]};
        h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c[4]};
        r  = s[7:0]; co = s[8]; hc = h[4];
        v  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        s  = {1'b0, a} - {1'b0, b};
        r  = s[7:0]; co = s[8];
        v  = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    if (c[5]) r = r >> 1;
    return {3'b000, co, v, (r == 8'h00), r[7], hc, r};
  endfunction

  // ---------------- ALU wrapper model ----------------
  // Captures the bus one cycle after each strobe; Done (with the low byte)
  // comes in the second WAIT_DONE cycle; the high byte follows one cycle later
  // and depends on the MUL bit still visible on the bus.
  bit          no_done = 1'b0;
  bit          spur = 1'b0;
  logic        pa, pb, pc;
  logic [7:0]  wa, wb, wc;
  logic [15:0] rm, ra;
  int          phase;
  logic [7:0]  junk;

  always @(posedge clk) junk <= 8'($urandom);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pa <= 1'b0; pb <= 1'b0; pc <= 1'b0;
      wa <= 8'h00; wb <= 8'h00; wc <= 8'h00;
      rm <= 16'h0; ra <= 16'h0; phase <= 0;
    end else begin
      pa <= LoadA_o; pb <= LoadB_o; pc <= LoadCmd_o;
      if (pa) wa <= ABCmd_o;
      if (pb) wb <= ABCmd_o;
      if (pc) begin
        wc    <= ABCmd_o;
        rm    <= 16'(wa) * 16'(wb);
        ra    <= ref_alu(wa, wb, {1'b0, ABCmd_o[6:0]});
        phase <= 1;
      end else if (phase != 0) begin
        phase <= (phase == 3) ? 0 : phase + 1;
      end
    end
  end

  always_comb begin
    Done_i = 1'b0;
    ACC_i  = junk;
    if (phase == 2 && !no_done) begin
      Done_i = 1'b1;
      ACC_i  = wc[7] ? rm[7:0] : ra[7:0];
    end else if (phase == 3) begin
      ACC_i  = ABCmd_o[7] ? rm[15:8] : ra[15:8];
    end
    if (spur) Done_i = 1'b1;
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct packed {
    logic       err;
    logic [7:0] hi;
    logic [7:0] lo;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_onehot0", int'($onehot0({LoadA_o, LoadB_o, LoadCmd_o})), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_lo", rsp_lo, mon_e.lo);
          chk("rsp_hi", rsp_hi, mon_e.hi);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_ops();
    req_a = 8'($urandom); req_b = 8'($urandom); req_cmd = 8'($urandom);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input bit nd, input bit sp, input int bp, input bit chaos,
                       input bit imm);
    int          w, cnt;
    logic [2:0]  sexp;
    logic [7:0]  bexp, s_lo, s_hi;
    logic        s_err;
    logic [15:0] r;
    rsp_t        e;
    no_done   = nd;
    rsp_ready = (bp == 0);
    req_valid = 1'b1; req_a = a; req_b = b; req_cmd = c;
    w = 0;
    while (!req_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    chk("req_ready_wait_bound", int'(w < 40), 1);
    if (imm) chk("accept_next_cycle", w, 0);
    @(posedge clk); #1;                       // acceptance edge
    if (nd) begin
      e.err = 1'b1; e.hi = 8'h00; e.lo = 8'h00;
    end else begin
      r = ref_alu(a, b, c);
      e.err = 1'b0; e.hi = r[15:8]; e.lo = r[7:0];
    end
    exp_q.push_back(e);
    chk("err_clear_on_accept", rsp_err, 0);
    chk("req_ready_low_busy", req_ready, 0);
    if (chaos) rand_ops(); else req_valid = 1'b0;
    spur = sp;
    cnt = 0;
    while (!rsp_valid && cnt < 30) begin
      if (cnt == 4) spur = 1'b0;              // SEND_A..EXEC only
      if (cnt < 6) begin
        sexp = (cnt == 0) ? 3'b100 : (cnt == 1) ? 3'b010 : (cnt == 2) ? 3'b001 : 3'b000;
        bexp = (cnt < 2) ? a : (cnt == 2) ? b : c;
        chk($sformatf("strobes_c%0d", cnt), {LoadA_o, LoadB_o, LoadCmd_o}, sexp);
        chk($sformatf("bus_c%0d", cnt), ABCmd_o, bexp);
      end
      if (chaos) rand_ops();
      @(posedge clk); #1; cnt++;
    end
    spur = 1'b0;
    chk("rsp_latency", cnt, nd ? 4 + TIMEOUT : 7);
    if (bp > 0) begin
      s_lo = rsp_lo; s_hi = rsp_hi; s_err = rsp_err;
      for (int i = 0; i < bp; i++) begin
        chk("bp_valid", rsp_valid, 1);
        chk("bp_lo_stable", rsp_lo, s_lo);
        chk("bp_hi_stable", rsp_hi, s_hi);
        chk("bp_err_stable", rsp_err, s_err);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_no_strobe", {LoadA_o, LoadB_o, LoadCmd_o, ABCmd_o}, 0);
        if (chaos) rand_ops();
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;                       // handshake edge
    chk("idle_req_ready", req_ready, 1);
    chk("rsp_valid_drop", rsp_valid, 0);
    no_done = 1'b0;
    $display("op a=%02h b=%02h cmd=%02h nd=%0d sp=%0d bp=%0d chaos=%0d -> exp lo=%02h hi=%02h err=%0d",
             a, b, c, nd, sp, bp, chaos, e.lo, e.hi, e.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    bit prev_chaos, nd, sp, ch;
    int bp;

    // Asynchronous reset: outputs must settle before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    chk("rst_rsp_hi", rsp_hi, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_bus_strobes", {LoadA_o, LoadB_o, LoadCmd_o, ABCmd_o}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_op(8'h0F, 8'h0F, 8'h80, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // MUL 0xE1
    do_op(8'hFF, 8'hFF, 8'h80, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // MUL 0xFE01
    do_op(8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);  // timeout
    do_op(8'h7F, 8'h01, 8'h10, 1'b0, 1'b0, 5, 1'b1, 1'b0);  // backpressure + chaos
    do_op(8'h55, 8'hAA, 8'h04, 1'b0, 1'b1, 0, 1'b0, 1'b1);  // immediate accept, spurious Done

    // Reset while in HOLD_B.
    req_valid = 1'b1; req_a = 8'hC3; req_b = 8'h3C; req_cmd = 8'h80;
    @(posedge clk); #1;                       // acceptance
    req_valid = 1'b0;
    @(posedge clk); #1;                       // HOLD_A
    @(posedge clk); #1;                       // HOLD_B
    chk("holdb_loadcmd", LoadCmd_o, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_loadcmd", LoadCmd_o, 0);
    chk("rst_mid_bus", ABCmd_o, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_no_strobe", {LoadA_o, LoadB_o, LoadCmd_o, ABCmd_o}, 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    do_op(8'h03, 8'h05, 8'h80, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // 0x000F

    // Randomized operations.
    prev_chaos = 1'b0;
    for (int k = 0; k < 40; k++) begin
      nd = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 3) == 0);
      bp = $urandom_range(0, 3);
      ch = ($urandom_range(0, 3) == 0);
      do_op(8'($urandom), 8'($urandom), 8'($urandom), nd, sp, bp, ch, prev_chaos);
      prev_chaos = ch;
    end
    req_valid = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
